// File: rtl/vga_sync_decoder.sv
// Recovers active-area pixel coordinates from raw VGA syncs and declares lock once
// the measured line/frame geometry has matched the configured timing for LOCK_FRAMES frames.
module vga_sync_decoder #(
  parameter int unsigned HD          = 640,
  parameter int unsigned HF          = 16,
  parameter int unsigned HB          = 48,
  parameter int unsigned HPW         = 96,
  parameter int unsigned VD          = 480,
  parameter int unsigned VF          = 10,
  parameter int unsigned VB          = 29,
  parameter int unsigned VPW         = 2,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [3:0] r_out,
  output logic [3:0] g_out,
  output logic [3:0] b_out,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [9:0] h_period,
  output logic [9:0] v_period
);

  localparam int unsigned HTot    = HD + HF + HB + HPW;
  localparam int unsigned VTot    = VD + VF + VB + VPW;
  localparam int unsigned WdRaw   = 2 * HTot - 1;
  localparam logic [9:0]  HTotW   = 10'(HTot);
  localparam logic [9:0]  VTotW   = 10'(VTot);
  localparam logic [9:0]  HStart  = 10'(HPW + HB);
  localparam logic [9:0]  HEnd    = 10'(HPW + HB + HD - 1);
  localparam logic [9:0]  VStart  = 10'(VPW + VB);
  localparam logic [9:0]  VEnd    = 10'(VPW + VB + VD - 1);
  localparam logic [9:0]  CntMax  = 10'd1023;
  localparam logic [9:0]  WdLimit = (WdRaw > 1023) ? CntMax : 10'(WdRaw);
  localparam int unsigned GoodW   = $clog2(LOCK_FRAMES + 1);
  localparam logic [GoodW-1:0] LockCnt = GoodW'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrain, StLocked} state_e;

  logic             r_hs_meta, r_hs_sync, r_hs_prev;
  logic             r_vs_meta, r_vs_sync, r_vs_prev;
  logic [11:0]      r_rgb_d1, r_rgb_d2;
  logic [9:0]       r_hcnt, r_vcnt;
  logic             r_vpend;
  logic [9:0]       r_h_period, r_v_period;
  state_e           r_state;
  logic [GoodW-1:0] r_good_cnt;
  logic             r_frame_bad;
  logic             r_sync_err;
  logic [9:0]       r_pix_x, r_pix_y;
  logic [11:0]      r_rgb_out;
  logic             r_pix_valid, r_frame_start;

  logic             w_line_start, w_frame_edge, w_reload;
  logic [9:0]       w_hcnt_inc, w_vcnt_inc, w_hcnt, w_vcnt;
  logic             w_vpend_nxt, w_h_bad, w_v_bad, w_wd;
  state_e           w_state_nxt;
  logic [GoodW-1:0] w_good_nxt, w_good_inc;
  logic             w_frame_bad_nxt, w_err_nxt;
  logic             w_active, w_pix_valid_nxt;
  logic [9:0]       w_px, w_py;

  // Syncs get a 2-flop synchronizer plus an edge-detect flop; RGB follows the same depth.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_hs_meta <= 1'b0;
      r_hs_sync <= 1'b0;
      r_hs_prev <= 1'b0;
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_rgb_d1  <= '0;
      r_rgb_d2  <= '0;
    end else begin
      r_hs_meta <= h_sync;
      r_hs_sync <= r_hs_meta;
      r_hs_prev <= r_hs_sync;
      r_vs_meta <= v_sync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_rgb_d1  <= {r_in, g_in, b_in};
      r_rgb_d2  <= r_rgb_d1;
    end
  end

  assign w_line_start = r_hs_prev & ~r_hs_sync;
  assign w_frame_edge = r_vs_prev & ~r_vs_sync;
  assign w_reload     = w_line_start & (r_vpend | w_frame_edge);

  // w_hcnt/w_vcnt are the counts of the pixel currently at the synchronizer output.
  always_comb begin
    w_hcnt_inc  = (r_hcnt == CntMax) ? CntMax : r_hcnt + 10'd1;
    w_vcnt_inc  = (r_vcnt == CntMax) ? CntMax : r_vcnt + 10'd1;
    w_hcnt      = w_line_start ? 10'd0 : w_hcnt_inc;
    w_vcnt      = r_vcnt;
    w_vpend_nxt = r_vpend | w_frame_edge;
    if (w_reload) begin
      w_vcnt      = 10'd0;
      w_vpend_nxt = 1'b0;
    end else if (w_line_start) begin
      w_vcnt = w_vcnt_inc;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_vpend    <= 1'b0;
      r_h_period <= '0;
      r_v_period <= '0;
    end else begin
      r_hcnt  <= w_hcnt;
      r_vcnt  <= w_vcnt;
      r_vpend <= w_vpend_nxt;
      if (w_line_start) r_h_period <= w_hcnt_inc;
      if (w_reload)     r_v_period <= w_vcnt_inc;
    end
  end

  assign w_h_bad    = w_line_start & (w_hcnt_inc != HTotW);
  assign w_v_bad    = w_reload & (w_vcnt_inc != VTotW);
  assign w_wd       = (w_hcnt == WdLimit);
  assign w_good_inc = r_good_cnt + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_good_nxt      = r_good_cnt;
    w_frame_bad_nxt = r_frame_bad;
    w_err_nxt       = 1'b0;
    unique case (r_state)
      StSearch: begin
        if (w_reload) begin
          w_state_nxt     = StTrain;
          w_good_nxt      = '0;
          w_frame_bad_nxt = 1'b0;
        end
      end
      StTrain: begin
        if (w_h_bad) begin
          w_good_nxt      = '0;
          w_frame_bad_nxt = 1'b1;
        end
        // A frame only counts if none of its lines was off-length.
        if (w_reload) begin
          w_frame_bad_nxt = 1'b0;
          if (r_frame_bad || w_h_bad || w_v_bad) begin
            w_good_nxt = '0;
          end else begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LockCnt) w_state_nxt = StLocked;
          end
        end
      end
      StLocked: begin
        if (w_h_bad || w_v_bad) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StSearch;
        end
      end
      default: w_state_nxt = StSearch;
    endcase
    if (w_wd) begin
      w_err_nxt   = (r_state == StLocked);
      w_state_nxt = StSearch;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_state     <= StSearch;
      r_good_cnt  <= '0;
      r_frame_bad <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_nxt;
      r_frame_bad <= w_frame_bad_nxt;
      r_sync_err  <= w_err_nxt;
    end
  end

  assign w_active = (w_hcnt >= HStart) && (w_hcnt <= HEnd) &&
                    (w_vcnt >= VStart) && (w_vcnt <= VEnd);
  assign w_px     = w_hcnt - HStart;
  assign w_py     = w_vcnt - VStart;
  // Gate with the next state so pix_valid never outlives the locked flag.
  assign w_pix_valid_nxt = w_active && (w_state_nxt == StLocked);

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_rgb_out     <= '0;
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_x       <= w_px;
      r_pix_y       <= w_py;
      r_rgb_out     <= r_rgb_d2;
      r_pix_valid   <= w_pix_valid_nxt;
      r_frame_start <= w_pix_valid_nxt && (w_px == 10'd0) && (w_py == 10'd0);
    end
  end

  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign r_out       = r_rgb_out[11:8];
  assign g_out       = r_rgb_out[7:4];
  assign b_out       = r_rgb_out[3:0];
  assign pix_valid   = r_pix_valid;
  assign frame_start = r_frame_start;
  assign locked      = (r_state == StLocked);
  assign sync_err    = r_sync_err;
  assign h_period    = r_h_period;
  assign v_period    = r_v_period;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 25x15 raster: the frame driver queues
// expected pixels, lock changes and sync_err pulses; a negedge monitor pops and compares them.
module tb_vga_sync_decoder;

  localparam int HD = 16, HF = 2, HB = 3, HPW = 4;
  localparam int VD = 8, VF = 2, VB = 3, VPW = 2;
  localparam int HTOT = HD + HF + HB + HPW;  // 25
  localparam int VTOT = VD + VF + VB + VPW;  // 15
  localparam int HS   = HPW + HB;            // 7
  localparam int VS   = VPW + VB;            // 5

  logic       clk_25MHz = 1'b0;
  logic       reset, h_sync, v_sync;
  logic [3:0] r_in, g_in, b_in, r_out, g_out, b_out;
  logic [9:0] pix_x, pix_y, h_period, v_period;
  logic       pix_valid, frame_start, locked, sync_err;

  vga_sync_decoder #(
    .HD(HD), .HF(HF), .HB(HB), .HPW(HPW),
    .VD(VD), .VF(VF), .VB(VB), .VPW(VPW), .LOCK_FRAMES(2)
  ) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_x(pix_x), .pix_y(pix_y), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err), .h_period(h_period), .v_period(v_period)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int cyc = 0;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  typedef struct {int cyc; int x; int y; logic [11:0] rgb;} pix_t;
  typedef struct {int cyc; bit val;} lk_t;
  pix_t pix_q[$];
  lk_t  lk_q[$];
  int   err_q[$];

  int checks = 0, passes = 0;
  int vld_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_locked = 1'b0;

  task automatic chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s, want %s", name, got, want);
  endtask

  task automatic check_zero(input string tag);
    chk(pix_x == 0 && pix_y == 0, {tag, "_coords"},
        $sformatf("x=%0d y=%0d", pix_x, pix_y), "0 0");
    chk({r_out, g_out, b_out} == 12'h000, {tag, "_colour"},
        $sformatf("%h", {r_out, g_out, b_out}), "000");
    chk({pix_valid, frame_start, locked, sync_err} == 4'b0000, {tag, "_flags"},
        $sformatf("%b", {pix_valid, frame_start, locked, sync_err}), "0000");
    chk(h_period == 0 && v_period == 0, {tag, "_periods"},
        $sformatf("h=%0d v=%0d", h_period, v_period), "0 0");
  endtask

  always @(negedge clk_25MHz) begin
    if (mon_en) begin
      if (pix_valid) begin
        pix_t e;
        vld_cnt <= vld_cnt + 1;
        if (pix_q.size() == 0) begin
          chk(1'b0, "unexpected_pix_valid", $sformatf("cyc=%0d x=%0d y=%0d", cyc, pix_x, pix_y),
              "no valid pixel");
        end else begin
          e = pix_q.pop_front();
          chk(cyc == e.cyc && int'(pix_x) == e.x && int'(pix_y) == e.y &&
              {r_out, g_out, b_out} == e.rgb && frame_start == (e.x == 0 && e.y == 0),
              "pixel",
              $sformatf("cyc=%0d x=%0d y=%0d rgb=%h fs=%b", cyc, pix_x, pix_y,
                        {r_out, g_out, b_out}, frame_start),
              $sformatf("cyc=%0d x=%0d y=%0d rgb=%h fs=%b", e.cyc, e.x, e.y, e.rgb,
                        (e.x == 0 && e.y == 0)));
        end
      end else if (frame_start) begin
        chk(1'b0, "frame_start_without_valid", $sformatf("cyc=%0d fs=1", cyc), "fs=0");
      end
      if (sync_err) begin
        if (err_q.size() == 0) chk(1'b0, "unexpected_sync_err", $sformatf("cyc=%0d", cyc),
                                   "no pulse");
        else begin
          int ec;
          ec = err_q.pop_front();
          chk(cyc == ec, "sync_err_cycle", $sformatf("%0d", cyc), $sformatf("%0d", ec));
        end
      end
      if (locked != prev_locked) begin
        if (lk_q.size() == 0) chk(1'b0, "unexpected_locked_change",
                                  $sformatf("cyc=%0d locked=%b", cyc, locked), "no change");
        else begin
          lk_t l;
          l = lk_q.pop_front();
          chk(cyc == l.cyc && locked == l.val, "locked_change",
              $sformatf("cyc=%0d locked=%b", cyc, locked),
              $sformatf("cyc=%0d locked=%b", l.cyc, l.val));
        end
      end
      prev_locked <= locked;
    end
  end

  // One source frame. valid: DUT is expected locked when the frame begins.
  // short_l: line one clock short; hold_l: h_sync held high through lines hold_l, hold_l+1;
  // rst_at: one-cycle reset at that pixel index; rel_at: reset released at that index.
  task automatic drive_frame(input int fnum, input bit valid, input bit lock_rise,
                             input int short_l, input int hold_l, input int rst_at,
                             input int rel_at);
    int cut, len, idx, x, y, bb;
    bit act, hs;
    cut = VTOT * HTOT;
    if (short_l >= 0) cut = (short_l + 1) * HTOT;
    if (hold_l >= 0)  cut = hold_l * HTOT;
    if (rst_at >= 0)  cut = rst_at - 2;
    for (int l = 0; l < VTOT; l++) begin
      len = (l == short_l) ? HTOT - 1 : HTOT;
      for (int h = 0; h < len; h++) begin
        @(posedge clk_25MHz);
        #1;
        idx = l * HTOT + h;
        if (l == 0 && h == 0 && lock_rise) lk_q.push_back('{cyc + 3, 1'b1});
        if (idx == rel_at) reset = 1'b0;
        if (idx == rst_at) begin
          reset = 1'b1;
          if (valid) lk_q.push_back('{cyc + 1, 1'b0});
        end else if (rst_at >= 0 && idx == rst_at + 1) begin
          reset = 1'b0;
          check_zero("mid_reset");
        end
        if (valid && h == 0 && short_l >= 0 && l == short_l + 1) begin
          err_q.push_back(cyc + 3);
          lk_q.push_back('{cyc + 3, 1'b0});
        end
        if (valid && h == 0 && hold_l >= 0 && l == hold_l - 1) begin
          err_q.push_back(cyc + 2 * HTOT + 2);
          lk_q.push_back('{cyc + 2 * HTOT + 2, 1'b0});
        end
        hs = (h >= HPW) || (hold_l >= 0 && (l == hold_l || l == hold_l + 1));
        h_sync = hs;
        v_sync = (l >= VPW);
        x = h - HS;
        y = l - VS;
        act = (x >= 0) && (x < HD) && (y >= 0) && (y < VD);
        bb = x ^ y ^ fnum;
        r_in = act ? x[3:0] : 4'h0;
        g_in = act ? y[3:0] : 4'h0;
        b_in = act ? bb[3:0] : 4'h0;
        if (valid && act && idx < cut)
          pix_q.push_back('{cyc + 3, x, y, {x[3:0], y[3:0], bb[3:0]}});
      end
    end
  endtask

  task automatic check_locked_frame(input int n0, input string tag);
    chk(vld_cnt - n0 == HD * VD, {tag, "_valid_count"}, $sformatf("%0d", vld_cnt - n0),
        $sformatf("%0d", HD * VD));
    chk(h_period == 10'(HTOT), {tag, "_h_period"}, $sformatf("%0d", h_period),
        $sformatf("%0d", HTOT));
    chk(v_period == 10'(VTOT), {tag, "_v_period"}, $sformatf("%0d", v_period),
        $sformatf("%0d", VTOT));
    chk(locked == 1'b1, {tag, "_locked"}, $sformatf("%b", locked), "1");
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    h_sync = 1'b1;
    v_sync = 1'b1;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk_25MHz);
    #1;
    check_zero("reset");
    mon_en = 1'b1;

    // Frame 1 starts with syncs already low at reset release, so its edge is missed.
    drive_frame(1, 0, 0, -1, -1, -1, 2);
    drive_frame(2, 0, 0, -1, -1, -1, -1);
    drive_frame(3, 0, 0, -1, -1, -1, -1);
    n0 = vld_cnt;
    drive_frame(4, 1, 1, -1, -1, -1, -1);
    check_locked_frame(n0, "lock1");

    drive_frame(5, 1, 0, 6, -1, -1, -1);
    chk(locked == 1'b0, "short_line_unlocked", $sformatf("%b", locked), "0");
    drive_frame(6, 0, 0, -1, -1, -1, -1);
    drive_frame(7, 0, 0, -1, -1, -1, -1);
    n0 = vld_cnt;
    drive_frame(8, 1, 1, -1, -1, -1, -1);
    check_locked_frame(n0, "lock2");

    drive_frame(9, 1, 0, -1, 8, -1, -1);
    chk(locked == 1'b0, "watchdog_unlocked", $sformatf("%b", locked), "0");
    drive_frame(10, 0, 0, -1, -1, -1, -1);
    drive_frame(11, 0, 0, -1, -1, -1, -1);
    n0 = vld_cnt;
    drive_frame(12, 1, 1, -1, -1, -1, -1);
    check_locked_frame(n0, "lock3");

    drive_frame(13, 1, 0, -1, -1, 7 * HTOT + 12, -1);
    drive_frame(14, 0, 0, -1, -1, -1, -1);
    drive_frame(15, 0, 0, -1, -1, -1, -1);
    n0 = vld_cnt;
    drive_frame(16, 1, 1, -1, -1, -1, -1);
    check_locked_frame(n0, "lock4");

    repeat (8) @(posedge clk_25MHz);
    #1;
    mon_en = 1'b0;
    chk(pix_q.size() == 0, "pixels_outstanding", $sformatf("%0d", pix_q.size()), "0");
    chk(err_q.size() == 0, "sync_err_outstanding", $sformatf("%0d", err_q.size()), "0");
    chk(lk_q.size() == 0, "lock_events_outstanding", $sformatf("%0d", lk_q.size()), "0");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
